// File: rtl/io_timer_pkg.sv
// io_timer_pkg: register offsets, CTRL bit positions and reset constants shared by the timer block
package io_timer_pkg;
  localparam logic [13:0] TMR_CTRL = 14'd0;
  localparam logic [13:0] TMR_CMP  = 14'd1;
  localparam logic [13:0] TMR_CNT  = 14'd2;
  localparam logic [13:0] TMR_STAT = 14'd3;
  localparam logic [13:0] TMR_PRE  = 14'd4;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;
endpackage

// File: rtl/io_timer_prescaler.sv
// timer_prescaler: emits a one-cycle tick every pre+1 enabled cycles
module timer_prescaler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] pre,
  input  logic        pre_wr,
  output logic        tick
);
  logic [15:0] pre_cnt_q, pre_cnt_d;
  always_comb begin
    tick = en && pre_cnt_q == pre;
    pre_cnt_d = (!en || pre_wr || tick) ? '0 : pre_cnt_q + 16'd1;
  end
  always_ff @(posedge clk)
    if (!rst_n) pre_cnt_q <= '0;
    else pre_cnt_q <= pre_cnt_d;
endmodule

// File: rtl/io_timer.sv
// io_timer: DMA I/O bus timer with prescaler, compare match, auto-reload/one-shot and W1C status irq
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [13:0] BASE_ADR = 14'h3C0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_io_we,
  input  logic [13:0] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [13:0] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  output logic        timer_irq
);
  logic        en_q, en_d, auto_q, auto_d, ie_q, ie_d, match_q, match_d;
  logic [31:0] cmp_q, cmp_d, cnt_q, cnt_d, rd_data_q, rd_data_d;
  logic [15:0] pre_q, pre_d;
  logic        rd_hit_q, rd_hit_d;
  logic [13:0] woff, roff;
  logic        wr_ctrl, wr_cmp, wr_cnt, wr_stat, wr_pre, tick, match_ev;
  assign woff    = dma_io_wadr - BASE_ADR;
  assign roff    = dma_io_radr - BASE_ADR;
  assign wr_ctrl = dma_io_we && woff == TMR_CTRL;
  assign wr_cmp  = dma_io_we && woff == TMR_CMP;
  assign wr_cnt  = dma_io_we && woff == TMR_CNT;
  assign wr_stat = dma_io_we && woff == TMR_STAT;
  assign wr_pre  = dma_io_we && woff == TMR_PRE;
  timer_prescaler u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_q),
    .pre   (pre_q),
    .pre_wr(wr_pre),
    .tick  (tick)
  );
  // Bus writes take priority over the counter's own updates; the compare always sees the old CNT.
  always_comb begin
    match_ev  = tick && cnt_q == cmp_q;
    en_d      = wr_ctrl ? dma_io_wdata[CTRL_EN] : (match_ev && !auto_q) ? 1'b0 : en_q;
    auto_d    = wr_ctrl ? dma_io_wdata[CTRL_AUTO] : auto_q;
    ie_d      = wr_ctrl ? dma_io_wdata[CTRL_IE] : ie_q;
    cmp_d     = wr_cmp ? dma_io_wdata : cmp_q;
    pre_d     = wr_pre ? dma_io_wdata[15:0] : pre_q;
    cnt_d     = wr_cnt ? dma_io_wdata : !tick ? cnt_q : !match_ev ? cnt_q + 32'd1 : auto_q ? '0 : cmp_q;
    match_d   = match_ev || (match_q && !(wr_stat && dma_io_wdata[0]));
    rd_hit_d  = dma_io_radr_en && roff <= TMR_PRE;
    rd_data_d = !rd_hit_d ? rd_data_q
              : roff == TMR_CTRL ? {29'd0, ie_q, auto_q, en_q}
              : roff == TMR_CMP  ? cmp_q
              : roff == TMR_CNT  ? cnt_q
              : roff == TMR_STAT ? {31'd0, match_q}
              : {16'd0, pre_q};
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      ie_q      <= 1'b0;
      cmp_q     <= CMP_RST;
      cnt_q     <= '0;
      pre_q     <= '0;
      match_q   <= 1'b0;
      rd_hit_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      en_q      <= en_d;
      auto_q    <= auto_d;
      ie_q      <= ie_d;
      cmp_q     <= cmp_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      match_q   <= match_d;
      rd_hit_q  <= rd_hit_d;
      rd_data_q <= rd_data_d;
    end
  assign dma_io_rdata = rd_hit_q ? rd_data_q : dma_io_rdata_in;
  assign timer_irq    = match_q && ie_q;
endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: randomized self-checking bench; expected timings come from the (CMP-CNT+1)*(PRE+1) period rule
module tb_io_timer;
  import io_timer_pkg::*;
  localparam logic [13:0] BASE = 14'h3C0;
  logic        clk = 1'b0, rst_n = 1'b0, we = 1'b0, radr_en = 1'b0;
  logic [13:0] wadr = '0, radr = '0;
  logic [31:0] wdata = '0, rdata_in = 32'hDEAD_BEEF, rdata;
  logic        irq;
  int          checks = 0, errors = 0;

  io_timer #(.BASE_ADR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .dma_io_we(we), .dma_io_wadr(wadr), .dma_io_wdata(wdata),
    .dma_io_radr(radr), .dma_io_radr_en(radr_en), .dma_io_rdata_in(rdata_in),
    .dma_io_rdata(rdata), .timer_irq(irq)
  );

  always #5 clk = ~clk;

  // All bus tasks are entered and left at a negedge; the access lands on the next posedge.
  task automatic wr(input logic [13:0] off, input logic [31:0] d);
    we = 1'b1; wadr = BASE + off; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] off, output logic [31:0] d);
    radr_en = 1'b1; radr = BASE + off;
    @(negedge clk);
    radr_en = 1'b0;
    d = rdata;
  endtask

  task automatic wait_irq(input int bound, output int k);
    k = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (irq) begin k = i; break; end
    end
  endtask

  task automatic stop_timer();
    wr(TMR_CTRL, 32'd0);
    wr(TMR_STAT, 32'd1);
  endtask

  task automatic arm(input int pre, input int cmp, input logic [31:0] cnt0, input logic [31:0] ctrl);
    stop_timer();
    wr(TMR_PRE, 32'(pre));
    wr(TMR_CMP, 32'(cmp));
    wr(TMR_CNT, cnt0);
    wr(TMR_CTRL, ctrl);
  endtask

  task automatic test_reset();
    logic [31:0] exp_v[5] = '{32'd0, CMP_RST, 32'd0, 32'd0, 32'd0};
    logic [31:0] d;
    rdata_in = 32'h1357_9BDF;
    radr_en = 1'b1; radr = BASE + TMR_CMP;
    repeat (3) @(negedge clk);
    checks++;
    if (irq !== 1'b0 || rdata !== rdata_in) begin
      errors++; $display("FAIL reset_outputs: irq %b rdata %h, want irq 0 rdata %h", irq, rdata, rdata_in);
    end
    radr_en = 1'b0;
    rst_n = 1'b1;
    rdata_in = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      rd(14'(i), d);
      checks++;
      if (d !== exp_v[i]) begin errors++; $display("FAIL reset_reg%0d: got %h want %h", i, d, exp_v[i]); end
    end
  endtask

  task automatic test_regs();
    logic [31:0] c, cm, cn, p, d;
    for (int n = 0; n < 3; n++) begin
      c = $urandom & ~32'h1; cm = $urandom; cn = $urandom; p = $urandom;
      wr(TMR_CTRL, c); wr(TMR_CMP, cm); wr(TMR_CNT, cn); wr(TMR_PRE, p);
      rd(TMR_CTRL, d); checks++;
      if (d !== (c & 32'h7)) begin errors++; $display("FAIL regs_ctrl: got %h want %h", d, c & 32'h7); end
      rd(TMR_CMP, d); checks++;
      if (d !== cm) begin errors++; $display("FAIL regs_cmp: got %h want %h", d, cm); end
      rd(TMR_CNT, d); checks++;
      if (d !== cn) begin errors++; $display("FAIL regs_cnt: got %h want %h", d, cn); end
      rd(TMR_PRE, d); checks++;
      if (d !== (p & 32'hFFFF)) begin errors++; $display("FAIL regs_pre: got %h want %h", d, p & 32'hFFFF); end
    end
  endtask

  task automatic test_periodic();
    int k;
    arm(3, 4, 32'd0, 32'h7);
    wait_irq(200, k); checks++;
    if (k !== 20) begin errors++; $display("FAIL periodic_first: got %0d cycles want 20", k); end
    wr(TMR_STAT, 32'd1); checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL periodic_w1c: irq %b want 0", irq); end
    wait_irq(200, k); checks++;
    if (k !== 19) begin errors++; $display("FAIL periodic_second: got %0d cycles after clear want 19", k); end
  endtask

  task automatic test_random_period();
    int pre, cmp, cnt0, k, exp_k;
    for (int n = 0; n < 5; n++) begin
      pre = int'($urandom_range(3, 0)); cmp = int'($urandom_range(6, 2)); cnt0 = int'($urandom_range(cmp, 0));
      arm(pre, cmp, 32'(cnt0), 32'h7);
      exp_k = (cmp - cnt0 + 1) * (pre + 1);
      wait_irq(500, k); checks++;
      if (k !== exp_k) begin errors++; $display("FAIL rand_first pre=%0d cmp=%0d cnt=%0d: got %0d want %0d", pre, cmp, cnt0, k, exp_k); end
      wr(TMR_STAT, 32'd1);
      exp_k = (cmp + 1) * (pre + 1) - 1;
      wait_irq(500, k); checks++;
      if (k !== exp_k) begin errors++; $display("FAIL rand_reload pre=%0d cmp=%0d: got %0d want %0d", pre, cmp, k, exp_k); end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    int bad;
    arm(0, 2, 32'd0, 32'h1);
    repeat (2) @(negedge clk);
    rd(TMR_STAT, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL oneshot_early: got %h want 0", d); end
    rd(TMR_STAT, d); checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL oneshot_match: got %h want 1", d); end
    bad = 0;
    repeat (10) begin @(negedge clk); if (irq !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL oneshot_irq: high %0d cycles want 0", bad); end
    rd(TMR_CTRL, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL oneshot_en: got %h want 0", d); end
    rd(TMR_CNT, d); checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL oneshot_cnt: got %h want 2", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    int k;
    arm(0, 5, 32'hFFFF_FFFE, 32'h5);
    wait_irq(100, k); checks++;
    if (k !== 8) begin errors++; $display("FAIL wrap_match: got %0d cycles want 8", k); end
    rd(TMR_CNT, d); checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL wrap_cnt: got %h want 5", d); end
    rd(TMR_CTRL, d); checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL wrap_ctrl: got %h want 4", d); end
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    arm(7, 0, 32'd0, 32'h3);
    repeat (7) @(negedge clk);
    wr(TMR_CNT, 32'd100);
    rd(TMR_CNT, d); checks++;
    if (d !== 32'd100) begin errors++; $display("FAIL coll_cnt: got %h want 100", d); end
    rd(TMR_STAT, d); checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL coll_oldcnt_match: got %h want 1", d); end
    arm(0, 3, 32'd0, 32'h1);
    repeat (3) @(negedge clk);
    wr(TMR_STAT, 32'd1);
    rd(TMR_STAT, d); checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL coll_w1c: got %h want 1", d); end
    arm(0, 3, 32'd0, 32'h1);
    repeat (3) @(negedge clk);
    wr(TMR_CTRL, 32'h3);
    rd(TMR_CTRL, d); checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL coll_ctrl: got %h want 3", d); end
    stop_timer();
  endtask

  task automatic test_read_chain();
    logic [31:0] cm;
    cm = $urandom;
    wr(TMR_CMP, cm);
    rdata_in = 32'hA5A5_5A5A;
    radr_en = 1'b1; radr = BASE + 14'd5;
    #1; checks++;
    if (rdata !== 32'hA5A5_5A5A) begin errors++; $display("FAIL chain_miss_comb: got %h want a5a55a5a", rdata); end
    @(negedge clk);
    radr_en = 1'b0; checks++;
    if (rdata !== 32'hA5A5_5A5A) begin errors++; $display("FAIL chain_miss: got %h want a5a55a5a", rdata); end
    radr_en = 1'b1; radr = BASE + TMR_CMP;
    #1; checks++;
    if (rdata !== rdata_in) begin errors++; $display("FAIL chain_early: got %h want %h", rdata, rdata_in); end
    @(negedge clk);
    radr_en = 1'b0; checks++;
    if (rdata !== cm) begin errors++; $display("FAIL chain_hit: got %h want %h", rdata, cm); end
    @(negedge clk);
    rdata_in = $urandom;
    #1; checks++;
    if (rdata !== rdata_in) begin errors++; $display("FAIL chain_one_cycle: got %h want %h", rdata, rdata_in); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int k;
    arm(0, 1, 32'd0, 32'h7);
    wait_irq(50, k);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; checks++;
    if (k < 0 || irq !== 1'b0) begin errors++; $display("FAIL reset_mid_irq: irq %b rise %0d want irq 0 after rise", irq, k); end
    rd(TMR_CTRL, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_mid_ctrl: got %h want 0", d); end
    rd(TMR_CMP, d); checks++;
    if (d !== CMP_RST) begin errors++; $display("FAIL reset_mid_cmp: got %h want ffffffff", d); end
    rd(TMR_STAT, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_mid_stat: got %h want 0", d); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_regs();
    test_periodic();
    test_random_period();
    test_oneshot();
    test_wrap();
    test_collisions();
    test_read_chain();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
